// File: rtl/serial_adder_sequencer_if.sv
// Operand, result and full-adder bit-lane signals of serial_adder_sequencer.
// master = requester / consumer / external adder side, slave = the sequencer.
interface serial_adder_sequencer_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             cin_i;
    logic             fa_a_o;
    logic             fa_b_o;
    logic             fa_cin_o;
    logic             fa_sum_i;
    logic             fa_cout_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] sum_o;
    logic             cout_o;

    modport master (
        output in_valid_i, a_i, b_i, cin_i, out_ready_i, fa_sum_i, fa_cout_i,
        input  in_ready_o, fa_a_o, fa_b_o, fa_cin_o, out_valid_o, sum_o, cout_o
    );

    modport slave (
        input  in_valid_i, a_i, b_i, cin_i, out_ready_i, fa_sum_i, fa_cout_i,
        output in_ready_o, fa_a_o, fa_b_o, fa_cin_o, out_valid_o, sum_o, cout_o
    );
endinterface

// File: rtl/serial_adder_sequencer.sv
// Bit-serial add controller around an external full adder: WIDTH cycles from acceptance to result,
// result held until out_ready_i. SERIAL_ADDER_CHECK_EN adds a parallel-reference check driving err_o.
module serial_adder_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    serial_adder_sequencer_if.slave bus,
    output logic                    busy_o,
    output logic                    err_o
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
`ifdef SERIAL_ADDER_CHECK_EN
    logic [WIDTH:0]   ref_q, ref_d;
    logic             err_q, err_d;
`endif

    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        sum_sh_d  = sum_sh_q;
        res_d     = res_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        bit_cnt_d = bit_cnt_q;
`ifdef SERIAL_ADDER_CHECK_EN
        ref_d     = ref_q;
        err_d     = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid_i) begin
                    a_sh_d    = bus.a_i;
                    b_sh_d    = bus.b_i;
                    carry_d   = bus.cin_i;
                    sum_sh_d  = '0;
                    bit_cnt_d = '0;
`ifdef SERIAL_ADDER_CHECK_EN
                    ref_d = {1'b0, bus.a_i} + {1'b0, bus.b_i} + {{WIDTH{1'b0}}, bus.cin_i};
`endif
                    state_d   = RUN;
                end
            end
            RUN: begin
                a_sh_d    = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d    = {1'b0, b_sh_q[WIDTH-1:1]};
                sum_sh_d  = {bus.fa_sum_i, sum_sh_q[WIDTH-1:1]};
                carry_d   = bus.fa_cout_i;
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == CW'(WIDTH - 1)) begin
                    // Result registers load only here so sum_o/cout_o never show partial sums.
                    res_d   = sum_sh_d;
                    cout_d  = bus.fa_cout_i;
                    state_d = DONE;
`ifdef SERIAL_ADDER_CHECK_EN
                    if ({bus.fa_cout_i, sum_sh_d} != ref_q) err_d = 1'b1;
`endif
                end
            end
            DONE: begin
                if (bus.out_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q   <= IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            sum_sh_q  <= '0;
            res_q     <= '0;
            carry_q   <= 1'b0;
            cout_q    <= 1'b0;
            bit_cnt_q <= '0;
`ifdef SERIAL_ADDER_CHECK_EN
            ref_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            sum_sh_q  <= sum_sh_d;
            res_q     <= res_d;
            carry_q   <= carry_d;
            cout_q    <= cout_d;
            bit_cnt_q <= bit_cnt_d;
`ifdef SERIAL_ADDER_CHECK_EN
            ref_q     <= ref_d;
            err_q     <= err_d;
`endif
        end
    end

    assign bus.in_ready_o  = (state_q == IDLE);
    assign bus.out_valid_o = (state_q == DONE);
    assign bus.sum_o       = res_q;
    assign bus.cout_o      = cout_q;
    assign bus.fa_a_o      = (state_q == RUN) & a_sh_q[0];
    assign bus.fa_b_o      = (state_q == RUN) & b_sh_q[0];
    assign bus.fa_cin_o    = (state_q == RUN) & carry_q;
    assign busy_o          = (state_q != IDLE);
`ifdef SERIAL_ADDER_CHECK_EN
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif
endmodule
